// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encodings, level ceiling
// and score width.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_OVER  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  localparam int MAX_LEVEL = 7;
  localparam int SCORE_W   = 10;

  // Frames between object moves minus one: 7 at level 0 down to 0 at level 7.
  function automatic logic [2:0] level_period(input logic [2:0] lvl);
    return 3'(MAX_LEVEL) - lvl;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts frame ticks and emits move_tick on the frame where the count reaches
// period, then restarts; clear has priority and enable freezes the count.
module frame_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [2:0] period,
  output logic       move_tick
);

  logic [2:0] count;
  logic       at_period;

  // >= so a shortened period after a level-up never strands the count above it.
  assign at_period = (count >= period);
  assign move_tick = enable & frame_tick & at_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else if (clear) begin
      count <= 3'd0;
    end else if (enable && frame_tick) begin
      if (at_period) count <= 3'd0;
      else           count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: start/play/hit-recovery/game-over sequencing, score,
// lives, level and object move pacing. Define GAME_PAUSE_EN to add the pause port.
module game_sequencer
  import game_pkg::*;
#(
  parameter int START_LIVES       = 3,
  parameter int HIT_FRAMES        = 60,
  parameter int BOTTLES_PER_LEVEL = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               hit_shark,
  input  logic               got_bottle,
`ifdef GAME_PAUSE_EN
  input  logic               pause,
`endif
  output logic               move_tick,
  output logic               obj_reload,
  output logic               flash,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [2:0]         level,
  output logic [2:0]         state
);

  state_t     cur_st, nxt_st;
  logic       start_q, start_edge;
  logic [7:0] hit_cnt, bottle_cnt;
  logic       pause_pulse;

  logic load_game, take_hit, last_life, take_bottle, hit_dec, div_clear;

`ifdef GAME_PAUSE_EN
  assign pause_pulse = pause;
`else
  assign pause_pulse = 1'b0;
`endif

  assign start_edge = start & ~start_q;
  assign state      = cur_st;
  assign flash      = (cur_st == S_HIT) & hit_cnt[3];

  frame_divider u_frame_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (div_clear),
    .enable     (cur_st == S_PLAY),
    .frame_tick (frame_tick),
    .period     (level_period(level)),
    .move_tick  (move_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st  <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      start_q <= start;
    end
  end

  // Next state plus one-cycle datapath strobes; a hit outranks pause and bottle.
  always_comb begin
    nxt_st      = cur_st;
    load_game   = 1'b0;
    take_hit    = 1'b0;
    last_life   = 1'b0;
    take_bottle = 1'b0;
    hit_dec     = 1'b0;
    div_clear   = 1'b0;
    case (cur_st)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          load_game = 1'b1;
          div_clear = 1'b1;
          nxt_st    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (hit_shark) begin
          if (lives > 2'd1) begin
            take_hit = 1'b1;
            nxt_st   = S_HIT;
          end else begin
            last_life = 1'b1;
            nxt_st    = S_OVER;
          end
        end else if (pause_pulse) begin
          nxt_st = S_PAUSE;
        end else if (got_bottle) begin
          take_bottle = 1'b1;
        end
      end
      S_HIT: begin
        if (hit_cnt == 8'd0) begin
          div_clear = 1'b1;
          nxt_st    = S_PLAY;
        end else if (frame_tick) begin
          hit_dec = 1'b1;
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (pause_pulse) nxt_st = S_PLAY;
      end
`endif
      default: nxt_st = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obj_reload <= 1'b0;
      score      <= '0;
      lives      <= 2'd0;
      level      <= 3'd0;
      hit_cnt    <= 8'd0;
      bottle_cnt <= 8'd0;
    end else begin
      obj_reload <= load_game | take_hit;
      if (load_game) begin
        lives      <= 2'(START_LIVES);
        score      <= '0;
        level      <= 3'd0;
        hit_cnt    <= 8'd0;
        bottle_cnt <= 8'd0;
      end
      if (take_hit) begin
        lives   <= lives - 2'd1;
        hit_cnt <= 8'(HIT_FRAMES);
      end
      if (last_life) lives <= 2'd0;
      if (hit_dec) hit_cnt <= hit_cnt - 8'd1;
      if (take_bottle) begin
        if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
        if (bottle_cnt == 8'(BOTTLES_PER_LEVEL - 1)) begin
          bottle_cnt <= 8'd0;
          if (level != 3'(MAX_LEVEL)) level <= level + 3'd1;
        end else begin
          bottle_cnt <= bottle_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters; the pause
// scenario is compiled in when GAME_PAUSE_EN is defined.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       hit_shark = 1'b0;
  logic       got_bottle = 1'b0;
`ifdef GAME_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       move_tick, obj_reload, flash;
  logic [9:0] score;
  logic [1:0] lives;
  logic [2:0] level;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;
  int mt_cnt = 0;
  int rl_cnt = 0;
  int fl_hi  = 0;

  game_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .hit_shark  (hit_shark),
    .got_bottle (got_bottle),
`ifdef GAME_PAUSE_EN
    .pause      (pause),
`endif
    .move_tick  (move_tick),
    .obj_reload (obj_reload),
    .flash      (flash),
    .score      (score),
    .lives      (lives),
    .level      (level),
    .state      (state)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given inputs; pulse outputs sampled mid-cycle.
  task automatic drive_cycle(input logic ft, input logic gb, input logic hs, input logic st);
    @(posedge clk);
    #1;
    frame_tick = ft;
    got_bottle = gb;
    hit_shark  = hs;
    start      = st;
    #4;
    if (move_tick === 1'b1)  mt_cnt++;
    if (obj_reload === 1'b1) rl_cnt++;
    if (flash === 1'b1)      fl_hi++;
  endtask

  task automatic new_game();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    frame_tick = 0; got_bottle = 0; hit_shark = 0; start = 0;
`ifdef GAME_PAUSE_EN
    pause = 0;
`endif
    #10;
    rst_n = 1'b1;
    rl_cnt = 0;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0);
  endtask

  task automatic wait_out_hit();
    repeat (60) drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
    total++;
    if ({lives, score, level, flash, move_tick, obj_reload} !== 18'd0)
      $display("FAIL reset_outputs: got %h want 0", {lives, score, level, flash, move_tick, obj_reload});
    else passed++;
  endtask

  task automatic test_start();
    rst_n = 1'b1;
    rl_cnt = 0;
    drive_cycle(0, 0, 0, 1);
    total++;
    if (state !== 3'd0) $display("FAIL start_before_edge: got %0d want 0", state); else passed++;
    repeat (4) drive_cycle(0, 0, 0, 1);
    total++;
    if (state !== 3'd1) $display("FAIL start_state: got %0d want 1", state); else passed++;
    total++;
    if (lives !== 2'd3 || score !== 10'd0 || level !== 3'd0)
      $display("FAIL start_load: got lives=%0d score=%0d level=%0d want 3/0/0", lives, score, level);
    else passed++;
    total++;
    if (rl_cnt !== 1) $display("FAIL start_reload_once: got %0d want 1", rl_cnt); else passed++;
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 0, 1);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (rl_cnt !== 1 || score !== 10'd3 || lives !== 2'd3)
      $display("FAIL start_in_play_ignored: got reload=%0d score=%0d lives=%0d want 1/3/3", rl_cnt, score, lives);
    else passed++;
  endtask

  task automatic test_divider_level();
    new_game();
    mt_cnt = 0;
    repeat (24) drive_cycle(1, 0, 0, 0);
    total++;
    if (mt_cnt !== 3) $display("FAIL div_level0: got %0d want 3", mt_cnt); else passed++;
    repeat (69) drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (level !== 3'd6) $display("FAIL level_69: got %0d want 6", level); else passed++;
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (level !== 3'd7 || score !== 10'd70)
      $display("FAIL level_70: got level=%0d score=%0d want 7/70", level, score);
    else passed++;
    mt_cnt = 0;
    repeat (8) drive_cycle(1, 0, 0, 0);
    total++;
    if (mt_cnt !== 8) $display("FAIL div_level7: got %0d want 8", mt_cnt); else passed++;
  endtask

  task automatic test_hit();
    new_game();
    repeat (3) drive_cycle(1, 0, 0, 0);
    rl_cnt = 0;
    drive_cycle(0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd2 || lives !== 2'd2)
      $display("FAIL hit_enter: got state=%0d lives=%0d want 2/2", state, lives);
    else passed++;
    total++;
    if (rl_cnt !== 1) $display("FAIL hit_reload: got %0d want 1", rl_cnt); else passed++;
    mt_cnt = 0;
    fl_hi = 0;
    repeat (60) drive_cycle(1, 1, 1, 0);
    total++;
    if (mt_cnt !== 0) $display("FAIL hit_no_move: got %0d want 0", mt_cnt); else passed++;
    total++;
    if (fl_hi !== 29) $display("FAIL hit_flash_count: got %0d want 29", fl_hi); else passed++;
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd2) $display("FAIL hit_cnt_zero_state: got %0d want 2", state); else passed++;
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd1 || lives !== 2'd2 || score !== 10'd0 || flash !== 1'b0)
      $display("FAIL hit_exit: got state=%0d lives=%0d score=%0d flash=%0d want 1/2/0/0", state, lives, score, flash);
    else passed++;
    mt_cnt = 0;
    repeat (7) drive_cycle(1, 0, 0, 0);
    total++;
    if (mt_cnt !== 0) $display("FAIL hit_div_cleared_7: got %0d want 0", mt_cnt); else passed++;
    drive_cycle(1, 0, 0, 0);
    total++;
    if (mt_cnt !== 1) $display("FAIL hit_div_cleared_8: got %0d want 1", mt_cnt); else passed++;
  endtask

  task automatic test_hit_and_bottle();
    new_game();
    repeat (5) drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 1, 0);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (score !== 10'd5 || lives !== 2'd2 || state !== 3'd2)
      $display("FAIL hit_wins: got score=%0d lives=%0d state=%0d want 5/2/2", score, lives, state);
    else passed++;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd2 || lives !== 2'd2)
      $display("FAIL start_in_hit_ignored: got state=%0d lives=%0d want 2/2", state, lives);
    else passed++;
  endtask

  task automatic test_game_over();
    new_game();
    repeat (4) drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 1, 0);
    wait_out_hit();
    drive_cycle(0, 0, 1, 0);
    wait_out_hit();
    rl_cnt = 0;
    drive_cycle(0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd3 || lives !== 2'd0 || score !== 10'd4)
      $display("FAIL over_enter: got state=%0d lives=%0d score=%0d want 3/0/4", state, lives, score);
    else passed++;
    mt_cnt = 0;
    repeat (16) drive_cycle(1, 1, 1, 0);
    total++;
    if (mt_cnt !== 0 || rl_cnt !== 0 || score !== 10'd4 || state !== 3'd3)
      $display("FAIL over_hold: got move=%0d reload=%0d score=%0d state=%0d want 0/0/4/3", mt_cnt, rl_cnt, score, state);
    else passed++;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd1 || score !== 10'd0 || lives !== 2'd3 || rl_cnt !== 1)
      $display("FAIL over_restart: got state=%0d score=%0d lives=%0d reload=%0d want 1/0/3/1", state, score, lives, rl_cnt);
    else passed++;
  endtask

  task automatic test_score_saturate();
    new_game();
    repeat (1030) drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (score !== 10'd1023 || level !== 3'd7)
      $display("FAIL score_saturate: got score=%0d level=%0d want 1023/7", score, level);
    else passed++;
  endtask

  task automatic test_reset_in_hit();
    new_game();
    repeat (2) drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 1, 0);
    repeat (10) drive_cycle(1, 0, 0, 0);
    total++;
    if (state !== 3'd2) $display("FAIL rst_hit_setup: got %0d want 2", state); else passed++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== 3'd0) $display("FAIL rst_hit_state: got %0d want 0", state); else passed++;
    total++;
    if ({lives, score, level, flash, move_tick, obj_reload} !== 18'd0)
      $display("FAIL rst_hit_outputs: got %h want 0", {lives, score, level, flash, move_tick, obj_reload});
    else passed++;
    #10;
    rst_n = 1'b1;
    frame_tick = 0;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd1 || lives !== 2'd3)
      $display("FAIL rst_hit_restart: got state=%0d lives=%0d want 1/3", state, lives);
    else passed++;
  endtask

`ifdef GAME_PAUSE_EN
  task automatic pause_pulse_cycle();
    @(posedge clk);
    #1;
    frame_tick = 0; got_bottle = 0; hit_shark = 0; start = 0;
    pause = 1'b1;
    @(posedge clk);
    #1;
    pause = 1'b0;
  endtask

  task automatic test_pause();
    new_game();
    mt_cnt = 0;
    repeat (3) drive_cycle(1, 0, 0, 0);
    pause_pulse_cycle();
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd4) $display("FAIL pause_enter: got %0d want 4", state); else passed++;
    repeat (10) drive_cycle(1, 1, 0, 0);
    total++;
    if (mt_cnt !== 0 || score !== 10'd0)
      $display("FAIL pause_freeze: got move=%0d score=%0d want 0/0", mt_cnt, score);
    else passed++;
    pause_pulse_cycle();
    drive_cycle(0, 0, 0, 0);
    total++;
    if (state !== 3'd1) $display("FAIL pause_exit: got %0d want 1", state); else passed++;
    repeat (4) drive_cycle(1, 0, 0, 0);
    total++;
    if (mt_cnt !== 0) $display("FAIL pause_phase_4: got %0d want 0", mt_cnt); else passed++;
    drive_cycle(1, 0, 0, 0);
    total++;
    if (mt_cnt !== 1) $display("FAIL pause_phase_5: got %0d want 1", mt_cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_divider_level();
    test_hit();
    test_hit_and_bottle();
    test_game_over();
    test_score_saturate();
    test_reset_in_hit();
`ifdef GAME_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
